spmv_scratch_pad: RTL and testbench
===================================

SPMV_SCRATCH_PAD -- requirements
Module: spmv_scratch_pad

Interface
REQ-001 Parameter ADDR_W, default 13, scratchpad word-address width (8192 x 64-bit words).
REQ-002 Parameter FIFO_LOG2, default 3, response FIFO depth = 2**FIFO_LOG2 = 8 entries.
REQ-003 Parameter SKID, default 2, maximum loads a requester may issue after req_scratch_stall rises.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_scratch_ld  input  1  load request, one word per cycle asserted.
REQ-007 req_scratch_st  input  1  store request, one word per cycle asserted.
REQ-008 req_scratch_addr  input  ADDR_W  word address for ld and/or st.
REQ-009 req_scratch_d  input  64  store data.
REQ-010 req_scratch_stall  output  1  back-pressure to requester.
REQ-011 rsp_scratch_push  output  1  one-cycle valid pulse per load response word.
REQ-012 rsp_scratch_q  output  64  load response data, valid only with push.
REQ-013 rsp_scratch_stall  input  1  consumer back-pressure on responses.
REQ-014 err_overflow  output  1  sticky flag, load accepted with no response credit.

Function
REQ-015 Storage SHALL be a 2**ADDR_W x 64 synchronous single-address RAM; contents undefined after power-up and never cleared by reset.
REQ-016 A store SHALL write req_scratch_d to req_scratch_addr at the rising edge where req_scratch_st is high, regardless of req_scratch_stall.
REQ-017 A load SHALL be accepted at every rising edge where req_scratch_ld is high, regardless of req_scratch_stall.
REQ-018 ld and st in the same cycle SHALL share the address; the load returns the pre-write (old) data.
REQ-019 Load pipeline: edge E0 accept, E1 RAM data registered, E2 data written to FIFO; with empty FIFO and rsp_scratch_stall low, rsp_scratch_push SHALL be high in the cycle following E2 (fixed 3-edge minimum latency, push registered).
REQ-020 Responses SHALL be returned strictly in load-acceptance order, one word per push, never duplicated or dropped.
REQ-021 rsp_scratch_push SHALL be registered: asserted for the next cycle iff FIFO non-empty and rsp_scratch_stall low at the current edge; rsp_scratch_q SHALL be 0 when push is low.
REQ-022 Credit counter outstanding = FIFO occupancy + loads in RAM pipeline; range 0..2**FIFO_LOG2, width FIFO_LOG2+1, increments on accept, decrements on pop, both same edge = no change.
REQ-023 req_scratch_stall SHALL be combinational from registered state: high iff outstanding >= 2**FIFO_LOG2 - SKID.
REQ-024 A load accepted when outstanding == 2**FIFO_LOG2 SHALL be discarded and SHALL set err_overflow until reset.
REQ-025 FIFO full SHALL never coincide with a FIFO write when requester honours SKID; FIFO empty SHALL suppress push.
REQ-026 No internal state machine beyond pipeline valid bits; idle = outstanding 0.

Reset
REQ-027 On rst_n low, asynchronously: req_scratch_stall 0, rsp_scratch_push 0, rsp_scratch_q 0, err_overflow 0, outstanding 0, FIFO pointers 0, pipeline valids 0.
REQ-028 Reset mid-operation SHALL drop all in-flight and queued loads; completed stores persist in RAM.
REQ-029 First request SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-030 ADDR_W, 64-bit data width and default FIFO depth SHALL live in the shared spmv include header alongside the opcode constants.
REQ-031 The response queue SHALL be a separate sub-module spmv_fifo (parameterised width/depth, push/pop/full/empty/count).
REQ-032 RAM SHALL be a plain inferred array with registered read; no vendor primitives.

Verification
REQ-033 Store 0x0123456789ABCDEF to addr 5, load addr 5 next cycle -> one push 3 edges after load, q = 0x0123456789ABCDEF.
REQ-034 Same cycle st addr 7 data 0xAA and ld addr 7 (prior value 0x55) -> q = 0x55; later ld addr 7 -> 0xAA.
REQ-035 rsp_scratch_stall held high, loads back-to-back to addrs 0..5 -> req_scratch_stall high once outstanding reaches 6; release -> six pushes in order 0..5, no gaps, stall falls.
REQ-036 Load every cycle with 8 preloaded words, rsp_scratch_stall low -> push every cycle after latency, stall never asserts, err_overflow 0.
REQ-037 rsp_scratch_stall high, ignore req_scratch_stall, issue 9 loads -> err_overflow = 1, exactly 8 responses delivered after release.
REQ-038 Four loads in flight, pulse rst_n low mid-pipeline -> all outputs 0 immediately, no pushes afterwards, previously stored data readable after reset.

Source files
------------

// File: rtl/spmv_scratch_pad_pkg.sv
// Shared spmv constants: scratchpad geometry, data width, response queue depth
// and the request opcode encoding.
package spmv_scratch_pad_pkg;

   localparam int unsigned SPMV_ADDR_W    = 13;
   localparam int unsigned SPMV_DATA_W    = 64;
   localparam int unsigned SPMV_FIFO_LOG2 = 3;
   localparam int unsigned SPMV_SKID      = 2;

   typedef logic [SPMV_DATA_W-1:0] spmv_word_t;

   // Request opcode as seen on the {st, ld} strobe pair.
   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LD   = 2'b01,
      OP_ST   = 2'b10,
      OP_LDST = 2'b11
   } spmv_op_e;

endpackage

// File: rtl/spmv_scratch_pad_fifo.sv
// Response queue: first-word-fall-through FIFO with occupancy count.
module spmv_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned LOG2  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LOG2:0]    count
);

   localparam int unsigned DEPTH = 2**LOG2;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [LOG2-1:0]  wr_ptr;
   logic [LOG2-1:0]  rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (LOG2+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spmv_scratch_pad.sv
// 64-bit scratchpad RAM with credit-managed, in-order load response queue.
module spmv_scratch_pad
   import spmv_scratch_pad_pkg::*;
#(
   parameter int unsigned ADDR_W    = SPMV_ADDR_W,
   parameter int unsigned FIFO_LOG2 = SPMV_FIFO_LOG2,
   parameter int unsigned SKID      = SPMV_SKID
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_scratch_ld,
   input  logic              req_scratch_st,
   input  logic [ADDR_W-1:0] req_scratch_addr,
   input  logic [63:0]       req_scratch_d,
   output logic              req_scratch_stall,
   output logic              rsp_scratch_push,
   output logic [63:0]       rsp_scratch_q,
   input  logic              rsp_scratch_stall,
   output logic              err_overflow
);

   localparam int unsigned        DEPTH    = 2**FIFO_LOG2;
   localparam logic [FIFO_LOG2:0] CREDITS  = (FIFO_LOG2+1)'(DEPTH);
   localparam logic [FIFO_LOG2:0] STALL_AT = (FIFO_LOG2+1)'(DEPTH - SKID);

   spmv_word_t         ram [2**ADDR_W];
   spmv_word_t         rd_q;
   spmv_word_t         pipe_q;
   logic               rd_v;
   logic               pipe_v;
   logic [FIFO_LOG2:0] outstanding;
   logic               accept;
   logic               pop;
   spmv_word_t         fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_LOG2:0] fifo_count;

   assign accept            = req_scratch_ld && (outstanding != CREDITS);
   assign pop               = !fifo_empty && !rsp_scratch_stall;
   assign req_scratch_stall = (outstanding >= STALL_AT);

   // Read-first port: a load sharing the edge with a store sees the old word.
   always_ff @(posedge clk) begin
      if (req_scratch_ld) rd_q <= ram[req_scratch_addr];
      if (req_scratch_st) ram[req_scratch_addr] <= req_scratch_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v             <= 1'b0;
         pipe_v           <= 1'b0;
         pipe_q           <= '0;
         outstanding      <= '0;
         rsp_scratch_push <= 1'b0;
         rsp_scratch_q    <= '0;
         err_overflow     <= 1'b0;
      end else begin
         rd_v             <= accept;
         pipe_v           <= rd_v;
         pipe_q           <= rd_q;
         rsp_scratch_push <= pop;
         rsp_scratch_q    <= pop ? fifo_rdata : '0;
         if (req_scratch_ld && !accept) err_overflow <= 1'b1;
         case ({accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   spmv_fifo #(
      .WIDTH (SPMV_DATA_W),
      .LOG2  (FIFO_LOG2)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pipe_v),
      .wdata (pipe_q),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Credits cover every word in the pipeline, so the queue can never be full on a write.
   a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(pipe_v && fifo_full));
   a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_count <= outstanding);

endmodule

// File: tb/tb_spmv_scratch_pad.sv
// Self-checking bench for spmv_scratch_pad: transaction-level model plus directed scenarios.
module tb_spmv_scratch_pad;

   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_scratch_ld = 1'b0;
   logic          req_scratch_st = 1'b0;
   logic [AW-1:0] req_scratch_addr = '0;
   logic [63:0]   req_scratch_d = '0;
   logic          req_scratch_stall;
   logic          rsp_scratch_push;
   logic [63:0]   rsp_scratch_q;
   logic          rsp_scratch_stall = 1'b0;
   logic          err_overflow;

   always #5 clk = ~clk;

   spmv_scratch_pad #(
      .ADDR_W    (AW),
      .FIFO_LOG2 (3),
      .SKID      (2)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_scratch_ld    (req_scratch_ld),
      .req_scratch_st    (req_scratch_st),
      .req_scratch_addr  (req_scratch_addr),
      .req_scratch_d     (req_scratch_d),
      .req_scratch_stall (req_scratch_stall),
      .rsp_scratch_push  (rsp_scratch_push),
      .rsp_scratch_q     (rsp_scratch_q),
      .rsp_scratch_stall (rsp_scratch_stall),
      .err_overflow      (err_overflow)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: each accepted load becomes a queued word, poppable from 3 edges after
   // acceptance, one per edge while the consumer is not stalling; 8 credits total.
   typedef struct {
      logic [63:0] d;
      int          t;
   } ent_t;

   ent_t        pend[$];
   logic [63:0] mem_m [int];
   int          edge_n  = 0;
   int          outst   = 0;
   logic        exp_push = 1'b0;
   logic        exp_err  = 1'b0;
   logic [63:0] exp_q    = '0;

   always @(posedge clk or negedge rst_n) begin
      int   pre;
      ent_t e;
      if (!rst_n) begin
         pend.delete();
         outst    = 0;
         exp_push = 1'b0;
         exp_q    = '0;
         exp_err  = 1'b0;
      end else begin
         edge_n++;
         pre = outst;
         if (pend.size() > 0 && pend[0].t + 3 <= edge_n && !rsp_scratch_stall) begin
            exp_push = 1'b1;
            exp_q    = pend[0].d;
            void'(pend.pop_front());
            outst--;
         end else begin
            exp_push = 1'b0;
            exp_q    = '0;
         end
         if (req_scratch_ld) begin
            if (pre < 8) begin
               e.d = mem_m.exists(int'(req_scratch_addr)) ? mem_m[int'(req_scratch_addr)] : 'x;
               e.t = edge_n;
               pend.push_back(e);
               outst++;
            end else begin
               exp_err = 1'b1;
            end
         end
         if (req_scratch_st) mem_m[int'(req_scratch_addr)] = req_scratch_d;
      end
   end

   always @(negedge clk) begin
      chk("push", rsp_scratch_push, exp_push);
      chk("q", rsp_scratch_q, exp_q);
      chk("req_stall", req_scratch_stall, outst >= 6);
      chk("err", err_overflow, exp_err);
   end

   task automatic cyc(input logic ld, input logic st, input int addr, input logic [63:0] d);
      req_scratch_ld   = ld;
      req_scratch_st   = st;
      req_scratch_addr = AW'(addr);
      req_scratch_d    = d;
      @(posedge clk);
      #2;
      req_scratch_ld = 1'b0;
      req_scratch_st = 1'b0;
   endtask

   task automatic wait_push(output int k, output logic [63:0] d);
      k = -1;
      d = '0;
      for (int j = 1; j <= 12; j++) begin
         @(posedge clk);
         #1;
         if (rsp_scratch_push && k < 0) begin
            k = j;
            d = rsp_scratch_q;
         end
         #1;
      end
   endtask

   task automatic collect(input int ncyc, input int nld, input int base,
                          output int cnt, output int first, output int last,
                          output logic [63:0] firstq, output logic stall_seen);
      cnt = 0; first = -1; last = -1; firstq = '0; stall_seen = 1'b0;
      for (int j = 0; j < ncyc; j++) begin
         cyc(j < nld, 1'b0, base + j, '0);
         if (rsp_scratch_push) begin
            if (first < 0) begin
               first  = j;
               firstq = rsp_scratch_q;
            end
            last = j;
            cnt++;
         end
         if (req_scratch_stall) stall_seen = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int          k, cnt, first, last;
      logic [63:0] d, fq;
      logic        ss;

      #1 rst_n = 1'b0;
      @(posedge clk);
      #2;
      chk("rst_push", rsp_scratch_push, 1'b0);
      chk("rst_q", rsp_scratch_q, '0);
      chk("rst_stall", req_scratch_stall, 1'b0);
      chk("rst_err", err_overflow, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, i, 64'hA5A5_0000_0000_0000 + 64'(i));
      cyc(1'b0, 1'b1, 7, 64'h55);

      // store then load next cycle
      cyc(1'b0, 1'b1, 5, 64'h0123_4567_89AB_CDEF);
      cyc(1'b1, 1'b0, 5, '0);
      wait_push(k, d);
      chk("lat_st_ld", 64'(k), 64'd3);
      chk("q_st_ld", d, 64'h0123_4567_89AB_CDEF);

      // same-cycle store and load return the old word
      cyc(1'b1, 1'b1, 7, 64'hAA);
      wait_push(k, d);
      chk("q_ldst_old", d, 64'h55);
      cyc(1'b1, 1'b0, 7, '0);
      wait_push(k, d);
      chk("q_ldst_new", d, 64'hAA);

      // consumer stalled: requester stall at 6 outstanding, then ordered drain
      rsp_scratch_stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, i, '0);
         if (i == 4) chk("stall_at5", req_scratch_stall, 1'b0);
      end
      chk("stall_at6", req_scratch_stall, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 0, '0);
      rsp_scratch_stall = 1'b0;
      collect(12, 0, 0, cnt, first, last, fq, ss);
      chk("drain_cnt", 64'(cnt), 64'd6);
      chk("drain_gapless", 64'(last - first), 64'd5);
      chk("drain_first_q", fq, 64'hA5A5_0000_0000_0000);
      chk("drain_stall_low", req_scratch_stall, 1'b0);

      // streaming loads: push every cycle, no stall, no error
      collect(14, 8, 8, cnt, first, last, fq, ss);
      chk("stream_cnt", 64'(cnt), 64'd8);
      chk("stream_first", 64'(first), 64'd3);
      chk("stream_gapless", 64'(last - first), 64'd7);
      chk("stream_first_q", fq, 64'hA5A5_0000_0000_0008);
      chk("stream_no_stall", ss, 1'b0);
      chk("stream_no_err", err_overflow, 1'b0);

      // overflow: 9 loads into 8 credits
      rsp_scratch_stall = 1'b1;
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, i, '0);
      chk("ovf_err", err_overflow, 1'b1);
      chk("ovf_stall", req_scratch_stall, 1'b1);
      repeat (2) cyc(1'b0, 1'b0, 0, '0);
      rsp_scratch_stall = 1'b0;
      collect(14, 0, 0, cnt, first, last, fq, ss);
      chk("ovf_cnt", 64'(cnt), 64'd8);
      chk("ovf_first_q", fq, 64'hA5A5_0000_0000_0000);
      chk("ovf_err_sticky", err_overflow, 1'b1);

      // reset with four loads in flight
      for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, i, '0);
      chk("pre_rst_push", rsp_scratch_push, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_push", rsp_scratch_push, 1'b0);
      chk("mid_rst_q", rsp_scratch_q, '0);
      chk("mid_rst_stall", req_scratch_stall, 1'b0);
      chk("mid_rst_err", err_overflow, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      collect(8, 0, 0, cnt, first, last, fq, ss);
      chk("post_rst_no_push", 64'(cnt), 64'd0);
      cyc(1'b1, 1'b0, 5, '0);
      wait_push(k, d);
      chk("post_rst_lat", 64'(k), 64'd3);
      chk("post_rst_q5", d, 64'h0123_4567_89AB_CDEF);
      cyc(1'b1, 1'b0, 7, '0);
      wait_push(k, d);
      chk("post_rst_q7", d, 64'hAA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
